cpu_bus_bridge: RTL and testbench
=================================

# cpu_bus_bridge

Sits directly below the `cpu` top on its byte-wide memory bus and decodes each access to either main RAM or the memory-mapped IO window. CPU-issued UART writes go into a small FIFO, so a stalled UART transmitter never back-pressures the RAM path. The block generates the `io_buffer_full` indication the CPU consumes. It also returns RAM or IO read data on `cpu_din`, and flags the simulation-end write.

## Interface
- `FIFO_DEPTH`, 8: UART TX FIFO entries; power of two, ≥4.
- `AFULL_MARGIN`, 2: free slots remaining when `cpu_io_buffer_full` asserts.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; one clock; reset is asynchronous and active-low.
- `rdy_in`  in  1  CPU ready; when low, CPU-side accesses are ignored.
- `cpu_a`  in  32  CPU address; only [17:0] decoded.
- `cpu_wr`  in  1  1 = write.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  read data to CPU, valid one cycle after address.
- `cpu_io_buffer_full`  out  1  almost-full indication to CPU.
- `ram_a`  out  17  RAM address (`cpu_a[16:0]`).
- `ram_wr`  out  1  RAM write enable.
- `ram_din`  out  8  RAM write data.
- `ram_dout`  in  8  RAM read data, 1-cycle latency.
- `tx_data`  out  8  UART TX byte (FIFO head).
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  UART accepts byte this cycle.
- `rx_data`  in  8  UART RX byte.
- `rx_valid`  in  1  `rx_data` valid (1-cycle pulse).
- `sim_end`  out  1  one-cycle pulse on write to 0x30004.
- `tx_overflow`  out  1  sticky: a byte was dropped on full FIFO.

## Operation
- Decode: `io_sel = (cpu_a[17:16] == 2'b11)`. RAM otherwise.
- RAM path is combinational pass-through.
  - `ram_a = cpu_a[16:0]`, `ram_din = cpu_dout`.
  - `ram_wr = cpu_wr & ~io_sel & rdy_in`.
- IO write, 0x30000: push `cpu_dout` into the TX FIFO when `rdy_in`.
  - If the FIFO is full, drop the byte and set `tx_overflow`; it clears only on reset.
- IO write, 0x30004: `sim_end` pulses the next cycle; registered.
- IO writes to any other IO address: ignored.
- RX holding register: `rx_valid` loads `rx_data` and sets `rx_full`. A newer byte overwrites.
- IO read, 0x30000 with `rdy_in`: captures the holding byte (0x00 if `!rx_full`) into `io_rd_q`, and clears `rx_full`.
  - If `rx_valid` arrives in the same cycle, the new byte is loaded and `rx_full` stays set; the read returns the old value.
- IO read, 0x30004: returns 0x00.
- Read return: register `sel_io_q <= io_sel & ~cpu_wr`. Then `cpu_din = sel_io_q ? io_rd_q : ram_dout`.
- TX FIFO: circular, read/write pointers of log2(FIFO_DEPTH) bits, count of log2(FIFO_DEPTH)+1 bits.
  - `tx_valid = (count != 0)`; `tx_data = mem[rd_ptr]`.
  - Pop on `tx_valid & tx_ready`. Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: allowed in every state including full. Count is unchanged, no overflow.
- `cpu_io_buffer_full = (count >= FIFO_DEPTH - AFULL_MARGIN)`, decoded from the registered count.
- TX draining continues while `rdy_in` is low.

## Timing
- Reset values (asynchronous, on `rst_in` low):
  - count, pointers, `rx_full`, `io_rd_q`, `sel_io_q`, `sim_end`, `tx_overflow` = 0.
  - Hence `cpu_din = ram_dout`, `tx_valid = 0`, `cpu_io_buffer_full = 0`, `ram_wr = 0` while `cpu_wr = 0`.
  - FIFO memory contents are not reset.
- Reset mid-operation discards all queued TX bytes and any pending RX byte.
- Read latency: 1 cycle for both RAM and IO. `cpu_din` for the address presented at cycle N is valid at N+1.
- Push latency: a byte written at cycle N is visible on `tx_data` with `tx_valid = 1` at N+1.
- `cpu_io_buffer_full` rises in the cycle after the push that brings count to FIFO_DEPTH−AFULL_MARGIN. It falls in the cycle after the pop that takes count below that level.
- `tx_ready` is sampled only while `tx_valid = 1`.

## Test plan
- RAM write then read: write 0xA5 to 0x00123, then read 0x00123 → `ram_wr` pulses once; `cpu_din` = 0xA5 one cycle after the read address.
- Fill with `tx_ready = 0`: write 0x41..0x48 to 0x30000 → `cpu_io_buffer_full` = 1 after the 6th push; count = 8 after the 8th; no overflow. A 9th write sets `tx_overflow`, count stays 8.
- Drain: then hold `tx_ready = 1` → `tx_data` sequence 0x41..0x48 in order. `cpu_io_buffer_full` clears after the pop taking count to 5; `tx_valid` = 0 after 8 pops.
- Full plus simultaneous push/pop: at count 8, write 0x55 with `tx_ready = 1` → 0x41 popped, 0x55 queued, count stays 8, `tx_overflow` stays 0.
- RX and end: pulse `rx_valid` with 0x7A, then read 0x30000 → `cpu_din` = 0x7A. A second read → 0x00. Write to 0x30004 → `sim_end` is high for exactly 1 cycle.
- Reset mid-drain: assert `rst_in` low asynchronously with count 3 → `tx_valid`, count, `cpu_io_buffer_full` = 0 immediately. After release, the first push appears at `tx_data` unaffected by old contents.

Source files
------------

// File: rtl/cpu_bus_bridge_if.sv
// cpu_bus_bridge_if: byte-wide CPU bus plus RAM and UART side signals around the bridge.
interface cpu_bus_bridge_if;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        sim_end;
    logic        tx_overflow;

    modport slave (
        input  rdy_in, cpu_a, cpu_wr, cpu_dout, ram_dout, tx_ready, rx_data, rx_valid,
        output cpu_din, cpu_io_buffer_full, ram_a, ram_wr, ram_din, tx_data, tx_valid,
               sim_end, tx_overflow
    );

    modport master (
        output rdy_in, cpu_a, cpu_wr, cpu_dout, ram_dout, tx_ready, rx_data, rx_valid,
        input  cpu_din, cpu_io_buffer_full, ram_a, ram_wr, ram_din, tx_data, tx_valid,
               sim_end, tx_overflow
    );
endinterface

// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: decodes the CPU byte bus into RAM and an IO window with a UART TX FIFO and RX holding register.
module cpu_bus_bridge #(
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 2
) (
    input logic             clk_in,
    input logic             rst_in,
    cpu_bus_bridge_if.slave bus
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [17:0] TX_ADDR   = 18'h30000;
    localparam logic [17:0] END_ADDR  = 18'h30004;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_rx_full, r_sel_io, r_sim_end, r_tx_overflow;
    logic [7:0]    r_rx_data, r_io_rd;
    logic          w_io_sel, w_io_rd, w_rx_rd, w_tx_wr, w_full, w_pop, w_push;
    logic          w_unused;

    always_comb begin
        w_io_sel = bus.cpu_a[17:16] == 2'b11;
        w_io_rd  = bus.rdy_in & w_io_sel & ~bus.cpu_wr;
        w_rx_rd  = w_io_rd & (bus.cpu_a[17:0] == TX_ADDR);
        w_tx_wr  = bus.rdy_in & bus.cpu_wr & (bus.cpu_a[17:0] == TX_ADDR);
        w_full   = r_count == FULL_LVL;
        w_pop    = (r_count != '0) & bus.tx_ready;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        w_push   = w_tx_wr & (~w_full | w_pop);
    end

    assign w_unused               = ^bus.cpu_a[31:18];
    assign bus.ram_a              = bus.cpu_a[16:0];
    assign bus.ram_din            = bus.cpu_dout;
    assign bus.ram_wr             = bus.cpu_wr & ~w_io_sel & bus.rdy_in;
    assign bus.cpu_din            = r_sel_io ? r_io_rd : bus.ram_dout;
    assign bus.tx_valid           = r_count != '0;
    assign bus.tx_data            = r_mem[r_rd_ptr];
    assign bus.cpu_io_buffer_full = r_count >= AFULL_LVL;
    assign bus.sim_end            = r_sim_end;
    assign bus.tx_overflow        = r_tx_overflow;

    always_ff @(posedge clk_in)
        if (w_push) r_mem[r_wr_ptr] <= bus.cpu_dout;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tx_overflow <= 1'b0;
            r_sim_end     <= 1'b0;
            r_sel_io      <= 1'b0;
            r_io_rd       <= 8'h00;
            r_rx_data     <= 8'h00;
            r_rx_full     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count   <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_tx_wr & w_full & ~w_pop) r_tx_overflow <= 1'b1;
            r_sim_end <= bus.rdy_in & bus.cpu_wr & (bus.cpu_a[17:0] == END_ADDR);
            r_sel_io  <= w_io_sel & ~bus.cpu_wr;
            if (w_io_rd) r_io_rd <= (w_rx_rd & r_rx_full) ? r_rx_data : 8'h00;
            // a byte arriving with the read wins: it is loaded, the read sees the old one
            if (bus.rx_valid) begin
                r_rx_data <= bus.rx_data;
                r_rx_full <= 1'b1;
            end else if (w_rx_rd) begin
                r_rx_full <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_bus_bridge.sv
// tb_cpu_bus_bridge: directed and random stimulus checked against a queue-based model of the bridge.
module tb_cpu_bus_bridge;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;

    cpu_bus_bridge_if bus ();

    cpu_bus_bridge #(.FIFO_DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    bit [7:0] env_ram [131072];

    always @(posedge clk_in) begin
        if (bus.ram_wr) env_ram[bus.ram_a] <= bus.ram_din;
        bus.ram_dout <= env_ram[bus.ram_a];
    end

    bit [7:0] ref_ram [131072];
    bit [7:0] tx_q [$];
    bit       m_ovf, m_sim, rx_has;
    bit [7:0] rx_val, m_io, m_din;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        tx_q.delete();
        m_ovf  = 0;
        m_sim  = 0;
        rx_has = 0;
        rx_val = 0;
        m_io   = 0;
        m_din  = ref_ram[0];
    endtask

    task automatic idle_inputs();
        bus.rdy_in   = 0;
        bus.cpu_a    = 0;
        bus.cpu_wr   = 0;
        bus.cpu_dout = 0;
        bus.tx_ready = 0;
        bus.rx_valid = 0;
        bus.rx_data  = 0;
    endtask

    // One bus cycle, entered and left on a falling edge.
    task automatic step(input bit rdy, input logic [31:0] a, input bit wr, input logic [7:0] d,
                        input bit txr, input bit rxv, input logic [7:0] rxd);
        bit          io, pop, push, take;
        logic [17:0] pa;
        bus.rdy_in   = rdy;
        bus.cpu_a    = a;
        bus.cpu_wr   = wr;
        bus.cpu_dout = d;
        bus.tx_ready = txr;
        bus.rx_valid = rxv;
        bus.rx_data  = rxd;
        #1;
        pa = a[17:0];
        io = a[17:16] == 2'b11;
        chk("ram_wr", bus.ram_wr, wr && !io && rdy);
        chk("ram_a", bus.ram_a, a[16:0]);
        chk("ram_din", bus.ram_din, d);
        chk("tx_valid", bus.tx_valid, tx_q.size() != 0);
        if (tx_q.size() != 0) chk("tx_data", bus.tx_data, tx_q[0]);
        chk("afull", bus.cpu_io_buffer_full, tx_q.size() >= DEPTH - MARGIN);
        chk("cpu_din", bus.cpu_din, m_din);
        chk("sim_end", bus.sim_end, m_sim);
        chk("tx_overflow", bus.tx_overflow, m_ovf);
        if (io && !wr) begin
            if (rdy) m_io = (pa == 18'h30000 && rx_has) ? rx_val : 8'h00;
            m_din = m_io;
        end else begin
            m_din = ref_ram[a[16:0]];
        end
        if (rdy && !wr && pa == 18'h30000) rx_has = 0;
        if (rxv) begin
            rx_has = 1;
            rx_val = rxd;
        end
        if (wr && !io && rdy) ref_ram[a[16:0]] = d;
        pop  = tx_q.size() != 0 && txr;
        push = rdy && wr && pa == 18'h30000;
        take = tx_q.size() < DEPTH || pop;
        if (push && !take) m_ovf = 1;
        if (pop) void'(tx_q.pop_front());
        if (push && take) tx_q.push_back(d);
        m_sim = rdy && wr && pa == 18'h30004;
        @(negedge clk_in);
    endtask

    task automatic mid_reset();
        idle_inputs();
        #2 rst_in = 0;
        #1;
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_afull", bus.cpu_io_buffer_full, 1'b0);
        chk("rst_overflow", bus.tx_overflow, 1'b0);
        chk("rst_sim_end", bus.sim_end, 1'b0);
        chk("rst_ram_wr", bus.ram_wr, 1'b0);
        repeat (2) @(negedge clk_in);
        rst_in = 1;
        model_reset();
    endtask

    initial begin
        bit [31:0] r, a;
        bit [7:0]  d;
        int        sel, txp;
        idle_inputs();
        repeat (3) @(negedge clk_in);
        #1;
        chk("reset_tx_valid", bus.tx_valid, 1'b0);
        chk("reset_afull", bus.cpu_io_buffer_full, 1'b0);
        chk("reset_overflow", bus.tx_overflow, 1'b0);
        chk("reset_sim_end", bus.sim_end, 1'b0);
        chk("reset_cpu_din", bus.cpu_din, 8'h00);
        @(negedge clk_in);
        rst_in = 1;
        model_reset();
        step(1, 32'h0000_0123, 1, 8'hA5, 0, 0, 0);
        step(1, 32'h0000_0123, 0, 8'h00, 0, 0, 0);
        step(1, 32'h0000_0000, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h0003_0000, 1, 8'(8'h41 + i), 0, 0, 0);
        step(1, 32'h0003_0000, 1, 8'h55, 1, 0, 0);
        step(1, 32'h0003_0000, 1, 8'h66, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 32'h0003_0000, 1, 8'h77, 1, 0, 0);
        step(1, 32'h0000_0000, 0, 8'h00, 0, 1, 8'h7A);
        step(1, 32'h0003_0000, 0, 8'h00, 0, 0, 0);
        step(1, 32'h0003_0000, 0, 8'h00, 0, 0, 0);
        step(1, 32'h0003_0000, 0, 8'h00, 0, 1, 8'h3C);
        step(1, 32'h0003_0000, 0, 8'h00, 0, 0, 0);
        step(1, 32'h0003_0004, 0, 8'h00, 0, 0, 0);
        step(1, 32'h0003_0004, 1, 8'h01, 0, 0, 0);
        step(1, 32'h0000_0000, 0, 8'h00, 0, 0, 0);
        step(1, 32'h0000_0000, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h0003_0000, 1, 8'(8'h90 + i), 0, 0, 0);
        mid_reset();
        step(1, 32'h0003_0000, 1, 8'hC3, 0, 0, 0);
        step(1, 32'h0000_0000, 0, 8'h00, 1, 0, 0);
        step(1, 32'h0000_0000, 0, 8'h00, 0, 0, 0);
        txp = 10;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) txp = (txp == 10) ? 70 : 10;
            r   = $urandom();
            a   = $urandom();
            d   = 8'($urandom());
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                a[17:16] = 2'($urandom_range(0, 2));
                a[15:6]  = '0;
            end else if (sel < 7) begin
                a[17:0] = 18'h30000;
            end else if (sel < 9) begin
                a[17:0] = 18'h30004;
            end else begin
                a[17:16] = 2'b11;
            end
            step($urandom_range(0, 99) < 85, a, r[0], d, $urandom_range(0, 99) < txp,
                 $urandom_range(0, 99) < 10, 8'(r >> 8));
            if (i == 1500) mid_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
